// File: rtl/alu_operand_stage_if.sv
// Handshake and bus bundle for the ALU operand-fetch stage: instruction input,
// writeback port, flush and the registered slot presented to the ALU.
interface alu_operand_stage_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_mode;
  logic [AW-1:0]   in_rs1;
  logic [AW-1:0]   in_rs2;
  logic [AW-1:0]   in_rd;
  logic            in_use_imm;
  logic [XLEN-1:0] in_imm;

  logic            wb_en;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;

  logic            flush;

  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_mode;
  logic [XLEN-1:0] out_A;
  logic [XLEN-1:0] out_B;
  logic [AW-1:0]   out_rd;
  logic            out_illegal;

  modport master (
    output in_valid, in_mode, in_rs1, in_rs2, in_rd, in_use_imm, in_imm,
    output wb_en, wb_rd, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_mode, out_A, out_B, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_mode, in_rs1, in_rs2, in_rd, in_use_imm, in_imm,
    input  wb_en, wb_rd, wb_data, flush, out_ready,
    output in_ready, out_valid, out_mode, out_A, out_B, out_rd, out_illegal
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage in front of the 64-bit ALU: register file with writeback
// bypass, operand B select, and a single valid/ready slot kept coherent while stalled.
module alu_operand_stage #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_operand_stage_if.slave   bus
);

  logic [XLEN-1:0] regs [NREG];

  logic            wb_hit;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] op_b;
  logic            accept;
  logic            consume;

  logic            valid_q;
  logic [3:0]      mode_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [AW-1:0]   rd_q;
  logic            illegal_q;
  logic [AW-1:0]   rs1_q;
  logic [AW-1:0]   rs2_q;
  logic            use_imm_q;

  assign wb_hit = bus.wb_en && (bus.wb_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_hit) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Same-cycle writeback wins over the stored value so a dependent instruction
  // never sees stale data.
  always_comb begin
    src_a = regs[bus.in_rs1];
    if (bus.in_rs1 == '0) begin
      src_a = '0;
    end else if (wb_hit && (bus.wb_rd == bus.in_rs1)) begin
      src_a = bus.wb_data;
    end
  end

  always_comb begin
    src_b = regs[bus.in_rs2];
    if (bus.in_rs2 == '0) begin
      src_b = '0;
    end else if (wb_hit && (bus.wb_rd == bus.in_rs2)) begin
      src_b = bus.wb_data;
    end
  end

  assign op_b = bus.in_use_imm ? bus.in_imm : src_b;

  assign bus.in_ready = !bus.flush && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign consume      = valid_q && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  // A held slot tracks writebacks to its sources so the ALU sees current values
  // once the stall releases; an immediate B is never overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_imm_q <= 1'b0;
    end else if (accept) begin
      mode_q    <= bus.in_mode;
      a_q       <= src_a;
      b_q       <= op_b;
      rd_q      <= bus.in_rd;
      illegal_q <= (bus.in_mode > 4'd5);
      rs1_q     <= bus.in_rs1;
      rs2_q     <= bus.in_rs2;
      use_imm_q <= bus.in_use_imm;
    end else if (valid_q) begin
      if (wb_hit && (bus.wb_rd == rs1_q)) begin
        a_q <= bus.wb_data;
      end
      if (wb_hit && !use_imm_q && (bus.wb_rd == rs2_q)) begin
        b_q <= bus.wb_data;
      end
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_mode    = mode_q;
  assign bus.out_A       = a_q;
  assign bus.out_B       = b_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: queue scoreboard against an
// architectural model where a held slot always reflects current register values.
module tb_alu_operand_stage;
  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int NREG = 32;

  typedef struct {
    logic [3:0]      mode;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic            use_imm;
    logic [XLEN-1:0] imm;
  } instr_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_operand_stage_if #(.XLEN(XLEN), .AW(AW)) bus ();

  alu_operand_stage #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  instr_t          sb_q[$];
  instr_t          mon_e;
  logic [XLEN-1:0] model_regs [NREG];
  logic            model_take;
  int              checks = 0;
  int              errors = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] arch_read(input logic [AW-1:0] r);
    return (r == '0) ? '0 : model_regs[r];
  endfunction

  // Reference model: architectural register file plus the queue of accepted
  // instructions; operands are evaluated against the registers when checked.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q.delete();
      foreach (model_regs[i]) model_regs[i] = '0;
    end else begin
      model_take = !bus.flush && bus.in_valid && (sb_q.size() == 0 || bus.out_ready);
      if (bus.wb_en && bus.wb_rd != '0) model_regs[bus.wb_rd] = bus.wb_data;
      if (bus.flush) sb_q.delete();
      else if (sb_q.size() != 0 && bus.out_ready) void'(sb_q.pop_front());
      if (model_take)
        sb_q.push_back('{bus.in_mode, bus.in_rs1, bus.in_rs2, bus.in_rd, bus.in_use_imm, bus.in_imm});
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check_output("in_ready", 64'(bus.in_ready),
                   64'(!bus.flush && (sb_q.size() == 0 || bus.out_ready)));
      check_output("out_valid", 64'(bus.out_valid), 64'(sb_q.size() != 0));
      if (sb_q.size() != 0 && bus.out_valid) begin
        mon_e = sb_q[0];
        check_output("out_mode", 64'(bus.out_mode), 64'(mon_e.mode));
        check_output("out_illegal", 64'(bus.out_illegal), 64'(mon_e.mode > 4'd5));
        check_output("out_rd", 64'(bus.out_rd), 64'(mon_e.rd));
        check_output("out_A", bus.out_A, arch_read(mon_e.rs1));
        check_output("out_B", bus.out_B, mon_e.use_imm ? mon_e.imm : arch_read(mon_e.rs2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(
    input logic v, input logic [3:0] mode, input logic [AW-1:0] rs1,
    input logic [AW-1:0] rs2, input logic [AW-1:0] rd, input logic ui,
    input logic [XLEN-1:0] imm, input logic we, input logic [AW-1:0] wrd,
    input logic [XLEN-1:0] wd, input logic fl, input logic ordy);
    bus.in_valid   = v;
    bus.in_mode    = mode;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_rd      = rd;
    bus.in_use_imm = ui;
    bus.in_imm     = imm;
    bus.wb_en      = we;
    bus.wb_rd      = wrd;
    bus.wb_data    = wd;
    bus.flush      = fl;
    bus.out_ready  = ordy;
    tick();
  endtask

  task automatic idle(input logic ordy);
    apply_stimulus(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, ordy);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_mode = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_rd = '0; bus.in_use_imm = 1'b0; bus.in_imm = '0;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
    #1;
    check_output("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check_output("reset_out_A", bus.out_A, 64'd0);
    check_output("reset_out_B", bus.out_B, 64'd0);
    check_output("reset_out_mode", 64'(bus.out_mode), 64'd0);
    check_output("reset_out_illegal", 64'(bus.out_illegal), 64'd0);
    check_output("reset_out_rd", 64'(bus.out_rd), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    idle(1'b1);

    apply_stimulus(1'b1, 4'd2, 5'd3, 5'd4, 5'd1, 1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1);
    check_output("t1_valid", 64'(bus.out_valid), 64'd1);
    check_output("t1_A", bus.out_A, 64'd0);
    check_output("t1_mode", 64'(bus.out_mode), 64'd2);

    idle(1'b1);
    apply_stimulus(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b1, 5'd5, 64'h1234, 1'b0, 1'b1);
    apply_stimulus(1'b1, 4'd5, 5'd5, 5'd0, 5'd6, 1'b1, 64'hFF, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1);
    check_output("t2_A", bus.out_A, 64'h1234);
    check_output("t2_B", bus.out_B, 64'hFF);

    apply_stimulus(1'b1, 4'd2, 5'd7, 5'd7, 5'd8, 1'b0, 64'd0, 1'b1, 5'd7, 64'hDEAD_BEEF, 1'b0, 1'b1);
    check_output("t3_bypass_A", bus.out_A, 64'hDEAD_BEEF);
    check_output("t3_bypass_B", bus.out_B, 64'hDEAD_BEEF);
    apply_stimulus(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'd0, 1'b1, 5'd0, 64'hFFFF, 1'b0, 1'b1);
    apply_stimulus(1'b1, 4'd0, 5'd0, 5'd7, 5'd9, 1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1);
    check_output("t3_r0_A", bus.out_A, 64'd0);

    idle(1'b1);
    apply_stimulus(1'b1, 4'd3, 5'd1, 5'd9, 5'd10, 1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 4'd1, 5'd2, 5'd3, 5'd11, 1'b0, 64'd0, 1'b1, 5'd9, 64'h55, 1'b0, 1'b0);
    check_output("t4_stall_B", bus.out_B, 64'h55);
    check_output("t4_stall_ready", 64'(bus.in_ready), 64'd0);
    apply_stimulus(1'b1, 4'd1, 5'd2, 5'd3, 5'd11, 1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 4'(i), 5'(i + 1), 5'd9, 5'(i + 12), 1'b0, 64'd0,
                     1'b0, 5'd0, 64'd0, 1'b0, 1'b1);
      check_output("t4_beat_valid", 64'(bus.out_valid), 64'd1);
      check_output("t4_beat_rd", 64'(bus.out_rd), 64'(i + 12));
    end

    apply_stimulus(1'b1, 4'd2, 5'd1, 5'd1, 5'd3, 1'b0, 64'd0, 1'b1, 5'd2, 64'h77, 1'b1, 1'b0);
    check_output("t5_flush_valid", 64'(bus.out_valid), 64'd0);
    apply_stimulus(1'b1, 4'd2, 5'd2, 5'd0, 5'd4, 1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1);
    check_output("t5_reg2_A", bus.out_A, 64'h77);

    apply_stimulus(1'b1, 4'b1001, 5'd2, 5'd0, 5'd5, 1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1);
    check_output("t6_illegal", 64'(bus.out_illegal), 64'd1);
    check_output("t6_mode", 64'(bus.out_mode), 64'd9);
    idle(1'b0);
    rst = 1'b1;
    #1;
    check_output("t6_async_reset_valid", 64'(bus.out_valid), 64'd0);
    tick();
    rst = 1'b0;
    apply_stimulus(1'b1, 4'd2, 5'd5, 5'd7, 5'd1, 1'b0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1);
    check_output("t6_reset_A", bus.out_A, 64'd0);
    check_output("t6_reset_B", bus.out_B, 64'd0);

    // Narrow register range keeps bypass and stall-coherence hits frequent.
    for (int n = 0; n < 400; n++) begin
      apply_stimulus(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                     {$urandom(), $urandom()}, 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)), {$urandom(), $urandom()},
                     1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
    end
    repeat (3) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-fetch stage directly upstream of the 64-bit ALU.
- Holds the 32 x 64-bit architectural register file and reads two sources with writeback bypass.
- Selects register or immediate for operand B, then registers {mode, A, B, rd} into a valid/ready pipeline slot.
- The slot outputs drive the ALU's mode/A/B inputs; rd travels alongside for writeback.

Parameters:
- XLEN, 64, datapath width (matches ALU operands).
- NREG, 32, number of architectural registers.
- AW, 5, register address width (log2 NREG).

Ports:
- clk  input  1  stage clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  stage accepts the instruction this cycle.
- in_mode  input  4  ALU op: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 pass B, 5 XOR.
- in_rs1  input  AW  source register for A.
- in_rs2  input  AW  source register for B.
- in_rd  input  AW  destination register, carried through.
- in_use_imm  input  1  1: B = in_imm; 0: B = reg[in_rs2].
- in_imm  input  XLEN  immediate operand.
- wb_en  input  1  writeback enable.
- wb_rd  input  AW  writeback register.
- wb_data  input  XLEN  writeback value.
- flush  input  1  kill the held and incoming instruction.
- out_valid  output  1  slot holds a valid instruction for the ALU.
- out_ready  input  1  downstream consumes the slot this cycle.
- out_mode  output  4  registered ALU mode.
- out_A  output  XLEN  registered operand A.
- out_B  output  XLEN  registered operand B.
- out_rd  output  AW  registered destination.
- out_illegal  output  1  registered flag: in_mode was greater than 5.

Behaviour:
- Reset (async, rst=1): all NREG registers are set to 0. out_valid, out_illegal, out_mode, out_A, out_B and out_rd are all 0. Reset takes effect immediately and discards any in-flight slot.
- Register file:
  - Written on the clk rising edge when wb_en=1 and wb_rd!=0.
  - Register 0 always reads 0; writes to it are ignored.
- Reads are combinational with bypass:
  - src(r) = 0 if r==0.
  - Otherwise src(r) = wb_data if wb_en=1 and wb_rd==r.
  - Otherwise src(r) = reg[r].
- Operand select: A = src(in_rs1). B = in_imm if in_use_imm=1, else src(in_rs2).
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready).
  - Accept occurs when in_valid && in_ready.
  - On accept: the slot captures mode, A, B, rd and illegal = (in_mode > 5); out_valid <= 1.
  - Latency is 1 cycle from accept to out_valid.
  - Consume occurs when out_valid && out_ready. Consume without a simultaneous accept sets out_valid <= 0.
  - Simultaneous consume and accept replaces the slot, giving full throughput of 1 instruction per cycle.
- Stall coherence:
  - While out_valid=1 and out_ready=0, the slot retains its rs1, rs2 and use_imm.
  - If wb_en=1 and wb_rd!=0 matches a retained source, that operand is updated to wb_data at the edge. The B update applies only when use_imm=0.
  - When out_rd equals wb_rd, out_rd is unchanged.
- Flush:
  - Priority over accept and consume: out_valid <= 0 at the next edge.
  - An incoming instruction in the flush cycle is not accepted (in_ready=0).
  - The register file write in the flush cycle still occurs.
- Illegal mode: the instruction still passes with out_mode = in_mode and out_illegal=1. The downstream stage decides the action.
- Output payload is don't-care when out_valid=0, but it holds its last value. There are no glitches on registered outputs.

Test Plan:
- Reset, then accept rs1=3, rs2=4, mode=2 with no writes -> next cycle out_valid=1, out_A=0, out_B=0, out_mode=2, out_illegal=0.
- Write reg5=0x1234 (cycle N); in cycle N+1 accept rs1=5, use_imm=1, imm=0xFF, mode=5 -> out_A=0x1234, out_B=0xFF.
- Same cycle: wb_en, wb_rd=7, wb_data=0xDEAD_BEEF, and accept rs1=7, rs2=7 -> out_A=out_B=0xDEAD_BEEF (bypass). Then wb to rd=0 with 0xFFFF -> a later read of rs1=0 returns 0.
- Hold out_ready=0 with slot rs2=9; write reg9=0x55 -> out_B becomes 0x55 next cycle and in_ready=0 throughout. Release out_ready -> a back-to-back accept each cycle for 4 instructions gives 4 consecutive out_valid beats.
- Slot valid, assert flush with in_valid=1 and wb_en rd=2=0x77 -> in_ready=0, out_valid=0 next cycle, and a later read of reg2 returns 0x77.
- Accept mode=4'b1001 -> out_illegal=1, out_mode=9. Assert rst mid-stall -> out_valid=0 immediately (before the next edge) and reg reads return 0.
